// File: rtl/cam_pkg.sv
// Shared constants, opcodes, FSM states and response record for the CAM command front-end.
package cam_pkg;

    localparam int NB_MEM    = 14;
    localparam int SIZE_ADDR = 4;
    localparam int NB_SLOT   = 1 << SIZE_ADDR;
    localparam int KEY_W     = 8;
    localparam int CAM_AW    = 5;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRCH,
        ST_WAIT,
        ST_WR,
        ST_RSP
    } state_e;

    typedef struct packed {
        logic                 hit;
        logic [SIZE_ADDR-1:0] idx;
        logic                 full;
    } rsp_t;

    // One-hot bitmap mask for a slot index; indices past NB_MEM yield an empty mask.
    function automatic logic [NB_MEM-1:0] slot_mask(input logic [SIZE_ADDR-1:0] idx);
        logic [NB_SLOT-1:0] oh;
        oh = NB_SLOT'(1) << idx;
        return oh[NB_MEM-1:0];
    endfunction

endpackage

// File: rtl/cam_ctrl_if.sv
// Host command/response port of cam_ctrl: valid/ready command in, valid/ready response out.
interface cam_ctrl_if;
    import cam_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [KEY_W-1:0]     cmd_data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_hit;
    logic [SIZE_ADDR-1:0] rsp_idx;
    logic                 rsp_full;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_hit, rsp_idx, rsp_full
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_hit, rsp_idx, rsp_full
    );

endinterface

// File: rtl/cam_ctrl_alloc.sv
// Slot allocator: lowest clear bit of the valid bitmap, plus a flag that any slot is free.
module cam_ctrl_alloc
    import cam_pkg::*;
(
    input  logic [NB_MEM-1:0]    valid,
    output logic [SIZE_ADDR-1:0] free_idx,
    output logic                 any_free
);

    // Scan high to low so the last hit wins, leaving the lowest free index.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = NB_MEM - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = SIZE_ADDR'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_ctrl.sv
// cam_ctrl: host front-end sequencing a 14-entry CAM; the valid bitmap here owns slot allocation.
// Optional feature macro CAM_CTRL_STATS_EN adds saturating LOOKUP hit/miss counters.
module cam_ctrl
    import cam_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    cam_ctrl_if.slave         bus,
    output logic              tbl_full,
    output logic              cam_enable,
    output logic              cam_write,
    output logic [CAM_AW-1:0] cam_addr,
    output logic [KEY_W-1:0]  cam_data,
    input  logic [CAM_AW-1:0] cam_out,
    input  logic              cam_found
`ifdef CAM_CTRL_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [KEY_W-1:0]     data_q, data_d;
    logic [NB_MEM-1:0]    valid_q, valid_d;
    rsp_t                 rsp_q, rsp_d;
    logic [SIZE_ADDR-1:0] wr_idx_q, wr_idx_d;

    logic [SIZE_ADDR-1:0] free_idx;
    logic                 any_free;
    logic [SIZE_ADDR-1:0] m_idx;
    logic [NB_MEM-1:0]    m_mask;
    logic [NB_MEM-1:0]    wr_mask;
    logic                 m_live;
    logic                 unused_cam_bit;

    cam_ctrl_alloc u_alloc (
        .valid    (valid_q),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    // A CAM match only counts if the bitmap still owns that slot; stale entries stay in the CAM.
    assign m_idx          = cam_out[SIZE_ADDR-1:0];
    assign m_mask         = slot_mask(m_idx);
    assign m_live         = cam_found && |(valid_q & m_mask);
    assign wr_mask        = slot_mask(wr_idx_q);
    assign unused_cam_bit = cam_out[CAM_AW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.cmd_valid)
                         state_d = (op_e'(bus.cmd_op) == OP_CLEAR) ? ST_RSP : ST_SRCH;
            ST_SRCH: state_d = ST_WAIT;
            ST_WAIT: state_d = (op_q == OP_INSERT && !cam_found && any_free) ? ST_WR : ST_RSP;
            ST_WR:   state_d = ST_RSP;
            ST_RSP:  if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_RSP);
        cam_enable    = (state_q == ST_SRCH);
        cam_write     = (state_q == ST_WR);
    end

    assign bus.rsp_hit  = rsp_q.hit;
    assign bus.rsp_idx  = rsp_q.idx;
    assign bus.rsp_full = rsp_q.full;
    assign cam_addr     = {1'b0, wr_idx_q};
    assign cam_data     = data_q;
    assign tbl_full     = &valid_q;

    always_comb begin
        op_d     = op_q;
        data_d   = data_q;
        valid_d  = valid_q;
        rsp_d    = rsp_q;
        wr_idx_d = wr_idx_q;
        case (state_q)
            ST_IDLE: if (bus.cmd_valid) begin
                op_d   = op_e'(bus.cmd_op);
                data_d = bus.cmd_data;
                if (op_e'(bus.cmd_op) == OP_CLEAR) begin
                    valid_d = '0;
                    rsp_d   = '0;
                end
            end
            ST_WAIT: begin
                rsp_d = '0;
                case (op_q)
                    OP_LOOKUP: if (m_live) begin
                        rsp_d.hit = 1'b1;
                        rsp_d.idx = m_idx;
                    end
                    OP_INSERT: begin
                        if (cam_found) begin
                            // Key still sits in the CAM: revive its slot instead of writing again.
                            valid_d   = valid_q | m_mask;
                            rsp_d.hit = 1'b1;
                            rsp_d.idx = m_idx;
                        end else if (any_free) begin
                            wr_idx_d  = free_idx;
                            rsp_d.idx = free_idx;
                        end else begin
                            rsp_d.full = 1'b1;
                        end
                    end
                    OP_DELETE: if (m_live) begin
                        valid_d   = valid_q & ~m_mask;
                        rsp_d.hit = 1'b1;
                        rsp_d.idx = m_idx;
                    end
                    default: ;
                endcase
            end
            ST_WR:   valid_d = valid_q | wr_mask;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_LOOKUP;
            data_q   <= '0;
            valid_q  <= '0;
            rsp_q    <= '0;
            wr_idx_q <= '0;
        end else begin
            op_q     <= op_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            rsp_q    <= rsp_d;
            wr_idx_q <= wr_idx_d;
        end
    end

`ifdef CAM_CTRL_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == ST_WAIT && op_q == OP_LOOKUP) begin
            if (m_live) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: behavioural CAM on the pins, slot-table reference model, directed + random commands.
module tb_cam_ctrl;
    import cam_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cam_ctrl_if bus();

    logic        tbl_full, cam_enable, cam_write;
    logic [4:0]  cam_addr;
    logic [7:0]  cam_data;
    logic [4:0]  cam_out   = '0;
    logic        cam_found = 1'b0;
`ifdef CAM_CTRL_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    cam_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .tbl_full   (tbl_full),
        .cam_enable (cam_enable),
        .cam_write  (cam_write),
        .cam_addr   (cam_addr),
        .cam_data   (cam_data),
        .cam_out    (cam_out),
        .cam_found  (cam_found)
`ifdef CAM_CTRL_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    // Behavioural CAM: registered search result, contents survive controller reset.
    logic [7:0] cmem [16];
    logic       cwr  [16] = '{default: 1'b0};

    function automatic logic [5:0] cam_search(input logic [7:0] k);
        logic [5:0] r;
        r = 6'b011010;
        for (int i = 0; i < 16; i++)
            if (cwr[i] && cmem[i] == k) r = {2'b11, 4'(i)};
        return r;
    endfunction

    always @(posedge clk) begin
        if (cam_write) begin
            cmem[cam_addr[3:0]] <= cam_data;
            cwr[cam_addr[3:0]]  <= 1'b1;
        end
        if (cam_enable) {cam_found, cam_out} <= cam_search(cam_data);
    end

    int         wr_cnt  = 0;
    int         ovl_cnt = 0;
    logic [4:0] wr_addr = '0;
    always @(posedge clk) begin
        if (cam_write) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= cam_addr;
        end
        if (cam_write && cam_enable) ovl_cnt <= ovl_cnt + 1;
    end

    // Reference model: which key each slot physically holds, and which slots are owned.
    logic [7:0] m_key  [NB_MEM];
    logic       m_pres [NB_MEM];
    logic       m_val  [NB_MEM];
`ifdef CAM_CTRL_STATS_EN
    int m_hit_n = 0, m_miss_n = 0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_all_valid();
        logic a;
        a = 1'b1;
        for (int i = 0; i < NB_MEM; i++) a &= m_val[i];
        return a;
    endfunction

    task automatic model_cmd(input logic [1:0] op, input logic [7:0] k,
                             output logic eh, output logic [3:0] ei, output logic ef,
                             output int ew, output int el);
        int s, f;
        s = -1;
        for (int i = 0; i < NB_MEM; i++) if (m_pres[i] && m_key[i] == k) s = i;
        eh = 0; ei = 0; ef = 0; ew = 0; el = 3;
        case (op)
            2'd0: begin
                if (s >= 0 && m_val[s]) begin eh = 1; ei = 4'(s); end
`ifdef CAM_CTRL_STATS_EN
                if (eh) m_hit_n  = (m_hit_n  == 65535) ? 65535 : m_hit_n + 1;
                else    m_miss_n = (m_miss_n == 65535) ? 65535 : m_miss_n + 1;
`endif
            end
            2'd1: begin
                if (s >= 0) begin
                    m_val[s] = 1; eh = 1; ei = 4'(s);
                end else begin
                    f = -1;
                    for (int i = NB_MEM - 1; i >= 0; i--) if (!m_val[i]) f = i;
                    if (f >= 0) begin
                        m_key[f] = k; m_pres[f] = 1; m_val[f] = 1;
                        ei = 4'(f); ew = 1; el = 4;
                    end else ef = 1;
                end
            end
            2'd2: if (s >= 0 && m_val[s]) begin m_val[s] = 0; eh = 1; ei = 4'(s); end
            default: begin
                for (int i = 0; i < NB_MEM; i++) m_val[i] = 0;
                el = 1;
            end
        endcase
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] k, input int hold);
        logic eh, ef, got;
        logic [3:0] ei;
        int ew, el, lat, w0;
        model_cmd(op, k, eh, ei, ef, ew, el);
        @(negedge clk);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1; bus.cmd_op = op; bus.cmd_data = k;
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        bus.cmd_valid = 0;
        bus.cmd_data  = 8'($urandom);
        lat = 0; got = 0;
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) got = 1;
        end
        chk("latency", lat, el);
        chk("rsp_hit",  bus.rsp_hit,  eh);
        chk("rsp_idx",  bus.rsp_idx,  ei);
        chk("rsp_full", bus.rsp_full, ef);
        chk("tbl_full", tbl_full, m_all_valid());
        chk("cam_data_held", cam_data, k);
        chk("write_count", wr_cnt - w0, ew);
        if (ew == 1) chk("write_addr", wr_addr, {1'b0, ei});
        for (int h = 0; h < hold; h++) begin
            bus.cmd_valid = 1; bus.cmd_op = 2'd0; bus.cmd_data = 8'($urandom);
            @(negedge clk);
            chk("rsp_hold", {bus.rsp_valid, bus.cmd_ready, bus.rsp_hit, bus.rsp_idx, bus.rsp_full},
                {1'b1, 1'b0, eh, ei, ef});
        end
        bus.cmd_valid = 0;
        bus.rsp_ready = 1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 0;
        chk("rsp_drop", bus.rsp_valid, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_outs"},
            {bus.rsp_valid, bus.rsp_hit, bus.rsp_idx, bus.rsp_full, tbl_full,
             cam_enable, cam_write, cam_addr, cam_data}, '0);
    endtask

    initial begin
        int n;
        logic [1:0] op;
        for (int i = 0; i < NB_MEM; i++) begin m_val[i] = 0; m_pres[i] = 0; m_key[i] = 0; end
        rst_n = 0;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_data = 0; bus.rsp_ready = 0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1;

        run_cmd(OP_INSERT, 8'h5A, 0);
        run_cmd(OP_INSERT, 8'h5A, 0);
        run_cmd(OP_LOOKUP, 8'h33, 0);
        run_cmd(OP_CLEAR,  8'h00, 0);
        for (int k = 0; k < NB_MEM; k++) run_cmd(OP_INSERT, 8'(8'h10 + k), 0);
        chk("tbl_full_set", tbl_full, 1);
        run_cmd(OP_INSERT, 8'h77, 0);
        run_cmd(OP_DELETE, 8'h12, 0);
        run_cmd(OP_INSERT, 8'h12, 0);
        run_cmd(OP_CLEAR,  8'h00, 0);
        chk("tbl_full_clear", tbl_full, 0);
        run_cmd(OP_LOOKUP, 8'h10, 0);
        run_cmd(OP_INSERT, 8'h11, 5);

        // Reset while the CAM write is on the pins: write lost, bitmap emptied.
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_op = OP_INSERT; bus.cmd_data = 8'h99;
        @(posedge clk);
        #1;
        bus.cmd_valid = 0;
        n = 0;
        while (!cam_write && n < 8) begin @(negedge clk); n++; end
        chk("reached_wr", cam_write, 1);
        rst_n = 0;
        #1;
        check_reset("reset_mid_wr");
        for (int i = 0; i < NB_MEM; i++) m_val[i] = 0;
`ifdef CAM_CTRL_STATS_EN
        m_hit_n = 0; m_miss_n = 0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1;
        run_cmd(OP_LOOKUP, 8'h11, 0);
        run_cmd(OP_LOOKUP, 8'h99, 0);
        run_cmd(OP_INSERT, 8'h99, 0);

        for (int t = 0; t < 150; t++) begin
            n = $urandom_range(0, 99);
            op = (n < 35) ? OP_LOOKUP : (n < 70) ? OP_INSERT : (n < 95) ? OP_DELETE : OP_CLEAR;
            run_cmd(op, 8'($urandom_range(16, 39)), $urandom_range(0, 2));
        end

`ifdef CAM_CTRL_STATS_EN
        chk("hit_cnt",  hit_cnt,  m_hit_n);
        chk("miss_cnt", miss_cnt, m_miss_n);
        force dut.hit_cnt_q  = 16'hFFFF;
        force dut.miss_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        release dut.miss_cnt_q;
        m_hit_n = 65535; m_miss_n = 65535;
        run_cmd(OP_INSERT, 8'h42, 0);
        run_cmd(OP_LOOKUP, 8'h42, 0);
        run_cmd(OP_LOOKUP, 8'hEE, 0);
        chk("hit_cnt_sat",  hit_cnt,  m_hit_n);
        chk("miss_cnt_sat", miss_cnt, m_miss_n);
`endif

        chk("enable_write_overlap", ovl_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
